axi_lite_if_s_reg_slice: RTL and testbench

// Parametrised AXI4-Lite slave-to-interface bridge with per-channel register slices.

---
 rtl/axi_lite_if_s_reg_slice_if.sv | 39 +++
 rtl/axi_lite_if_s_reg_slice.sv | 136 +++++++++++++
 tb/tb_axi_lite_if_s_reg_slice.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_if_s_reg_slice_if.sv
// AXI4-Lite bus bundle carrying the five channels (AW, W, B, AR, R).
// The master view drives requests and accepts responses; the slave view mirrors it.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              aw_valid;
  logic [ADDR_W-1:0] aw_addr;
  logic              aw_ready;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic              b_valid;
  logic [1:0]        b_resp;
  logic              b_ready;
  logic              ar_valid;
  logic [ADDR_W-1:0] ar_addr;
  logic              ar_ready;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_ready;

  modport master (
    output aw_valid, aw_addr, input  aw_ready,
    output w_valid,  w_data,  input  w_ready,
    input  b_valid,  b_resp,  output b_ready,
    output ar_valid, ar_addr, input  ar_ready,
    input  r_valid,  r_data,  r_resp, output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, output aw_ready,
    input  w_valid,  w_data,  output w_ready,
    output b_valid,  b_resp,  input  b_ready,
    input  ar_valid, ar_addr, output ar_ready,
    output r_valid,  r_data,  r_resp, input r_ready
  );
endinterface

// File: rtl/axi_lite_if_s_reg_slice.sv
// Flat AXI4-Lite slave port to axi_lite_if master bridge: each of the five channels
// is either wired straight through or cut by a full-throughput two-entry skid slice.
module axil_skid_slice #(
  parameter int W   = 32,
  parameter bit REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  if (REG) begin : g_slice
    logic         main_valid;
    logic [W-1:0] main_data;
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         ready_q;
    logic         in_hs;
    logic         main_free;

    assign in_hs     = in_valid && ready_q;
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: payload flops are reset as well so the bus reads all-zero out of reset.
        main_valid <= 1'b0;
        main_data  <= '0;
        skid_valid <= 1'b0;
        skid_data  <= '0;
        ready_q    <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every branch sees the pre-edge state.
        if (main_free) begin
          if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end else begin
            main_valid <= in_hs;
            if (in_hs) main_data <= in_data;
          end
        end else if (in_hs) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
        // Registered ready tracks "skid will be empty after this edge".
        ready_q <= main_free || !(skid_valid || in_hs);
      end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
  end else begin : g_pass
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
  end
endmodule

module axi_lite_if_s_reg_slice #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}},
  parameter bit              REG_AW    = 1'b1,
  parameter bit              REG_W     = 1'b1,
  parameter bit              REG_B     = 1'b1,
  parameter bit              REG_AR    = 1'b1,
  parameter bit              REG_R     = 1'b1
) (
  input  logic              axil_aclk,
  input  logic              axil_aresetn,
  input  logic              s_axil_awvalid,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  output logic              s_axil_awready,
  input  logic              s_axil_wvalid,
  input  logic [DATA_W-1:0] s_axil_wdata,
  output logic              s_axil_wready,
  output logic              s_axil_bvalid,
  output logic [1:0]        s_axil_bresp,
  input  logic              s_axil_bready,
  input  logic              s_axil_arvalid,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  output logic              s_axil_arready,
  output logic              s_axil_rvalid,
  output logic [DATA_W-1:0] s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  input  logic              s_axil_rready,
  axi_lite_if.master        m_axil
);
  // The window mask sits ahead of the slice so both modes forward the same address.
  logic [ADDR_W-1:0] aw_addr_win;
  logic [ADDR_W-1:0] ar_addr_win;
  logic [DATA_W+1:0] r_in;
  logic [DATA_W+1:0] r_out;

  assign aw_addr_win = s_axil_awaddr & ADDR_MASK;
  assign ar_addr_win = s_axil_araddr & ADDR_MASK;
  assign r_in        = {m_axil.r_data, m_axil.r_resp};
  assign {s_axil_rdata, s_axil_rresp} = r_out;

  axil_skid_slice #(.W(ADDR_W), .REG(REG_AW)) u_aw (
    .clk(axil_aclk), .rst_n(axil_aresetn),
    .in_valid(s_axil_awvalid), .in_data(aw_addr_win), .in_ready(s_axil_awready),
    .out_valid(m_axil.aw_valid), .out_data(m_axil.aw_addr), .out_ready(m_axil.aw_ready)
  );

  axil_skid_slice #(.W(DATA_W), .REG(REG_W)) u_w (
    .clk(axil_aclk), .rst_n(axil_aresetn),
    .in_valid(s_axil_wvalid), .in_data(s_axil_wdata), .in_ready(s_axil_wready),
    .out_valid(m_axil.w_valid), .out_data(m_axil.w_data), .out_ready(m_axil.w_ready)
  );

  axil_skid_slice #(.W(2), .REG(REG_B)) u_b (
    .clk(axil_aclk), .rst_n(axil_aresetn),
    .in_valid(m_axil.b_valid), .in_data(m_axil.b_resp), .in_ready(m_axil.b_ready),
    .out_valid(s_axil_bvalid), .out_data(s_axil_bresp), .out_ready(s_axil_bready)
  );

  axil_skid_slice #(.W(ADDR_W), .REG(REG_AR)) u_ar (
    .clk(axil_aclk), .rst_n(axil_aresetn),
    .in_valid(s_axil_arvalid), .in_data(ar_addr_win), .in_ready(s_axil_arready),
    .out_valid(m_axil.ar_valid), .out_data(m_axil.ar_addr), .out_ready(m_axil.ar_ready)
  );

  axil_skid_slice #(.W(DATA_W + 2), .REG(REG_R)) u_r (
    .clk(axil_aclk), .rst_n(axil_aresetn),
    .in_valid(m_axil.r_valid), .in_data(r_in), .in_ready(m_axil.r_ready),
    .out_valid(s_axil_rvalid), .out_data(r_out), .out_ready(s_axil_rready)
  );
endmodule

// File: tb/tb_axi_lite_if_s_reg_slice.sv
// Bench for the AXI4-Lite register-slice bridge: a registered instance checked against
// a per-channel two-deep FIFO model, plus a passthrough instance checked combinationally.
module tb_axi_lite_if_s_reg_slice;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam logic [31:0] MASK   = 32'h0000_FFFF;
  localparam int          QD     = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              s_axil_awvalid, s_axil_wvalid, s_axil_bready, s_axil_arvalid, s_axil_rready;
  logic [ADDR_W-1:0] s_axil_awaddr, s_axil_araddr;
  logic [DATA_W-1:0] s_axil_wdata;
  logic              s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]        s_axil_bresp, s_axil_rresp;
  logic [DATA_W-1:0] s_axil_rdata;

  logic              pt_awready, pt_wready, pt_bvalid, pt_arready, pt_rvalid;
  logic [1:0]        pt_bresp, pt_rresp;
  logic [DATA_W-1:0] pt_rdata;

  axi_lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();
  axi_lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pif ();

  assign pif.aw_ready = mif.aw_ready;
  assign pif.w_ready  = mif.w_ready;
  assign pif.b_valid  = mif.b_valid;
  assign pif.b_resp   = mif.b_resp;
  assign pif.ar_ready = mif.ar_ready;
  assign pif.r_valid  = mif.r_valid;
  assign pif.r_data   = mif.r_data;
  assign pif.r_resp   = mif.r_resp;

  axi_lite_if_s_reg_slice #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_MASK(MASK)) dut (
    .axil_aclk(clk), .axil_aresetn(rst_n),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awaddr(s_axil_awaddr), .s_axil_awready(s_axil_awready),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wdata(s_axil_wdata), .s_axil_wready(s_axil_wready),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp), .s_axil_bready(s_axil_bready),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_araddr(s_axil_araddr), .s_axil_arready(s_axil_arready),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rready(s_axil_rready),
    .m_axil(mif)
  );

  axi_lite_if_s_reg_slice #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .REG_AW(1'b0), .REG_W(1'b0), .REG_B(1'b0), .REG_AR(1'b0), .REG_R(1'b0)
  ) dut_pt (
    .axil_aclk(clk), .axil_aresetn(rst_n),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awaddr(s_axil_awaddr), .s_axil_awready(pt_awready),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wdata(s_axil_wdata), .s_axil_wready(pt_wready),
    .s_axil_bvalid(pt_bvalid), .s_axil_bresp(pt_bresp), .s_axil_bready(s_axil_bready),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_araddr(s_axil_araddr), .s_axil_arready(pt_arready),
    .s_axil_rvalid(pt_rvalid), .s_axil_rdata(pt_rdata), .s_axil_rresp(pt_rresp),
    .s_axil_rready(s_axil_rready),
    .m_axil(pif)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each registered channel behaves as an in-order FIFO of depth 2 with one
  // cycle of latency; ready is low only while two beats are held.
  logic [63:0] exp_q [5][QD];
  int          wr_ptr [5];
  int          rd_ptr [5];
  bit          held [5];
  logic [63:0] held_pay [5];
  bit          in_hs [5];
  bit          armed = 1'b0;
  int          r_out_cnt = 0;
  string       cname [5] = '{"aw", "w", "b", "ar", "r"};

  task automatic mon(input int ch, input logic iv, input logic ir, input logic ov,
                     input logic orr, input logic [63:0] ipay, input logic [63:0] opay);
    int occ;
    occ = wr_ptr[ch] - rd_ptr[ch];
    if (!rst_n) begin
      check({cname[ch], "_rst_valid"}, 64'(ov), 64'd0);
      check({cname[ch], "_rst_ready"}, 64'(ir), 64'd0);
      check({cname[ch], "_rst_payload"}, opay, 64'd0);
      wr_ptr[ch] = 0;
      rd_ptr[ch] = 0;
      held[ch]   = 1'b0;
      in_hs[ch]  = 1'b0;
      return;
    end
    if (!armed) check({cname[ch], "_ready_before_first_clk"}, 64'(ir), 64'd0);
    else        check({cname[ch], "_ready"}, 64'(ir), 64'(occ < 2));
    check({cname[ch], "_valid"}, 64'(ov), 64'(occ > 0));
    if (held[ch] && ov) check({cname[ch], "_stable"}, opay, held_pay[ch]);
    if (ov && orr) begin
      if (occ > 0) begin
        check({cname[ch], "_order"}, opay, exp_q[ch][rd_ptr[ch] % QD]);
        rd_ptr[ch]++;
      end
      if (ch == 4) r_out_cnt++;
    end
    in_hs[ch] = iv && ir;
    if (in_hs[ch]) begin
      exp_q[ch][wr_ptr[ch] % QD] = ipay;
      wr_ptr[ch]++;
    end
    held[ch]     = ov && !orr;
    held_pay[ch] = opay;
  endtask

  initial begin
    for (int c = 0; c < 5; c++) begin
      wr_ptr[c] = 0; rd_ptr[c] = 0; held[c] = 1'b0; in_hs[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      mon(0, s_axil_awvalid, s_axil_awready, mif.aw_valid, mif.aw_ready,
          64'(s_axil_awaddr & MASK), 64'(mif.aw_addr));
      mon(1, s_axil_wvalid, s_axil_wready, mif.w_valid, mif.w_ready,
          64'(s_axil_wdata), 64'(mif.w_data));
      mon(2, mif.b_valid, mif.b_ready, s_axil_bvalid, s_axil_bready,
          64'(mif.b_resp), 64'(s_axil_bresp));
      mon(3, s_axil_arvalid, s_axil_arready, mif.ar_valid, mif.ar_ready,
          64'(s_axil_araddr & MASK), 64'(mif.ar_addr));
      mon(4, mif.r_valid, mif.r_ready, s_axil_rvalid, s_axil_rready,
          64'({mif.r_data, mif.r_resp}), 64'({s_axil_rdata, s_axil_rresp}));
      armed = rst_n;
      // Passthrough instance: every output equals its source in the same cycle.
      check("pt_aw_valid", 64'(pif.aw_valid), 64'(s_axil_awvalid));
      check("pt_aw_addr",  64'(pif.aw_addr),  64'(s_axil_awaddr));
      check("pt_awready",  64'(pt_awready),   64'(mif.aw_ready));
      check("pt_w_data",   64'(pif.w_data),   64'(s_axil_wdata));
      check("pt_wready",   64'(pt_wready),    64'(mif.w_ready));
      check("pt_bvalid",   64'(pt_bvalid),    64'(mif.b_valid));
      check("pt_b_ready",  64'(pif.b_ready),  64'(s_axil_bready));
      check("pt_ar_valid", 64'(pif.ar_valid), 64'(s_axil_arvalid));
      check("pt_arready",  64'(pt_arready),   64'(mif.ar_ready));
      check("pt_rdata",    64'({pt_rvalid, pt_rdata, pt_rresp}),
                           64'({mif.r_valid, mif.r_data, mif.r_resp}));
      check("pt_r_ready",  64'(pif.r_ready),  64'(s_axil_rready));
    end
  end

  function automatic logic coin(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // Sources hold valid and payload until the handshake, then may pick a new beat.
  task automatic rand_step(input int pv, input int pr);
    if (!s_axil_awvalid || in_hs[0]) begin s_axil_awvalid = coin(pv); s_axil_awaddr = $urandom; end
    if (!s_axil_wvalid  || in_hs[1]) begin s_axil_wvalid  = coin(pv); s_axil_wdata  = $urandom; end
    if (!mif.b_valid    || in_hs[2]) begin mif.b_valid    = coin(pv); mif.b_resp    = 2'($urandom); end
    if (!s_axil_arvalid || in_hs[3]) begin s_axil_arvalid = coin(pv); s_axil_araddr = $urandom; end
    if (!mif.r_valid    || in_hs[4]) begin
      mif.r_valid = coin(pv); mif.r_data = $urandom; mif.r_resp = 2'($urandom);
    end
    mif.aw_ready  = coin(pr);
    mif.w_ready   = coin(pr);
    s_axil_bready = coin(pr);
    mif.ar_ready  = coin(pr);
    s_axil_rready = coin(pr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    s_axil_awvalid = 1'b1; s_axil_awaddr = 32'hFFFF_FFFF;
    s_axil_wvalid  = 1'b1; s_axil_wdata  = 32'hFFFF_FFFF;
    s_axil_arvalid = 1'b1; s_axil_araddr = 32'hFFFF_FFFF;
    s_axil_bready  = 1'b1; s_axil_rready = 1'b1;
    mif.b_valid = 1'b1; mif.b_resp = 2'b11;
    mif.r_valid = 1'b1; mif.r_data = 32'hFFFF_FFFF; mif.r_resp = 2'b11;
    mif.aw_ready = 1'b1; mif.w_ready = 1'b1; mif.ar_ready = 1'b1;

    // Reset with every valid asserted.
    repeat (2) @(negedge clk);
    check("rst_awready",  64'(s_axil_awready), 64'd0);
    check("rst_m_aw_valid", 64'(mif.aw_valid), 64'd0);
    check("rst_m_b_ready", 64'(mif.b_ready),   64'd0);
    check("rst_bresp",    64'(s_axil_bresp),   64'd0);
    check("rst_rresp",    64'(s_axil_rresp),   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    mif.b_valid = 1'b0; mif.r_valid = 1'b0;
    @(negedge clk);
    check("arready_before_first_clk", 64'(s_axil_arready), 64'd0);
    @(negedge clk);
    check("arready_after_release", 64'(s_axil_arready), 64'd1);
    check("awready_after_release", 64'(s_axil_awready), 64'd1);
    check("wready_after_release",  64'(s_axil_wready),  64'd1);
    check("b_ready_after_release", 64'(mif.b_ready),    64'd1);
    check("r_ready_after_release", 64'(mif.r_ready),    64'd1);

    // Single write through the masked window.
    @(posedge clk); #1;
    s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h1234_5678;
    s_axil_wvalid  = 1'b1; s_axil_wdata  = 32'hDEAD_BEEF;
    mif.aw_ready = 1'b0; mif.w_ready = 1'b0;
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    @(negedge clk);
    check("wr_aw_valid", 64'(mif.aw_valid), 64'd1);
    check("wr_aw_addr",  64'(mif.aw_addr),  64'h0000_5678);
    check("wr_w_valid",  64'(mif.w_valid),  64'd1);
    check("wr_w_data",   64'(mif.w_data),   64'hDEAD_BEEF);
    @(posedge clk); #1;
    mif.aw_ready = 1'b1; mif.w_ready = 1'b1;
    s_axil_bready = 1'b0; mif.b_valid = 1'b1; mif.b_resp = 2'b00;
    @(posedge clk); #1;
    mif.b_valid = 1'b0;
    @(negedge clk);
    check("wr_bvalid",        64'(s_axil_bvalid), 64'd1);
    check("wr_bresp_okay",    64'(s_axil_bresp),  64'd0);
    check("wr_aw_consumed",   64'(mif.aw_valid),  64'd0);
    @(posedge clk); #1;
    mif.b_valid = 1'b1; mif.b_resp = 2'b10; s_axil_bready = 1'b1;
    @(posedge clk); #1;
    mif.b_valid = 1'b0;
    @(negedge clk);
    check("wr2_bvalid", 64'(s_axil_bvalid), 64'd1);
    check("wr2_bresp",  64'(s_axil_bresp),  64'd2);
    @(negedge clk);
    check("wr2_b_drained", 64'(s_axil_bvalid), 64'd0);

    // Streaming 16 back-to-back reads.
    for (int i = 0; i <= 16; i++) begin
      @(posedge clk); #1;
      mif.ar_ready = 1'b1;
      if (i < 16) begin s_axil_arvalid = 1'b1; s_axil_araddr = 32'(i); end
      else s_axil_arvalid = 1'b0;
      @(negedge clk);
      if (i > 0) begin
        check("stream_ar_valid", 64'(mif.ar_valid), 64'd1);
        check("stream_ar_addr",  64'(mif.ar_addr),  64'(i - 1));
      end
      check("stream_arready", 64'(s_axil_arready), 64'd1);
    end

    // Backpressure: three reads offered against a stalled sink.
    @(posedge clk); #1;
    mif.ar_ready = 1'b0; s_axil_arvalid = 1'b1; s_axil_araddr = 32'h100;
    @(posedge clk); #1;
    s_axil_araddr = 32'h104;
    @(posedge clk); #1;
    s_axil_araddr = 32'h108;
    @(negedge clk);
    check("bp_arready_low", 64'(s_axil_arready), 64'd0);
    check("bp_head_addr",   64'(mif.ar_addr),    64'h100);
    @(posedge clk); #1;
    mif.ar_ready = 1'b1;
    @(negedge clk);
    check("bp_arready_still_low", 64'(s_axil_arready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_second_addr",  64'(mif.ar_addr),    64'h104);
    check("bp_arready_back", 64'(s_axil_arready), 64'd1);
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    @(negedge clk);
    check("bp_third_addr", 64'(mif.ar_addr), 64'h108);
    @(negedge clk);
    check("bp_drained", 64'(mif.ar_valid), 64'd0);

    // Passthrough instance follows inputs within the same cycle.
    @(posedge clk); #1;
    s_axil_awvalid = 1'b1; s_axil_awaddr = 32'hCAFE_0000; mif.aw_ready = 1'b0;
    #1;
    check("pt_valid_same_cycle", 64'(pif.aw_valid), 64'd1);
    check("pt_ready_same_cycle", 64'(pt_awready),   64'd0);
    mif.aw_ready = 1'b1;
    #1;
    check("pt_ready_follows", 64'(pt_awready), 64'd1);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0;

    // Random traffic on all channels, with one reset in the middle of it.
    r_out_cnt = 0;
    for (int cyc = 0; cyc < 30000 && r_out_cnt < 1000; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 150) rst_n = 1'b0;
      else if (cyc == 153) rst_n = 1'b1;
      case ((cyc / 200) % 3)
        0:       rand_step(90, 90);
        1:       rand_step(50, 30);
        default: rand_step(75, 60);
      endcase
    end
    check("r_beats_reached", 64'(r_out_cnt >= 1000), 64'd1);

    // Drain: nothing may be left behind.
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    mif.b_valid = 1'b0; mif.r_valid = 1'b0;
    mif.aw_ready = 1'b1; mif.w_ready = 1'b1; mif.ar_ready = 1'b1;
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) check({cname[c], "_drain_occupancy"}, 64'(wr_ptr[c] - rd_ptr[c]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
